// File: rtl/pes_usr_seq.sv
// pes_usr_seq: sequences load/shift mode codes for a downstream 4-bit universal shift register.
// Optional PES_USR_SEQ_SER_OUT_EN adds a serial tap of the bit leaving the register each shift.
module pes_usr_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_dir,
    input  logic [2:0] in_len,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] usr_cnt,
    output logic [3:0] usr_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] shadow_q,
    output logic       ser_out,
    output logic       ser_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] data;
    logic       dir;
    logic [2:0] len;
    logic [2:0] rem;
    logic       accept;
    assign accept = (state == IDLE) && in_valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? LOAD : IDLE;
            LOAD:    state_nx = (len != 3'd0) ? SHIFT : DONE;
            SHIFT:   state_nx = (rem == 3'd1) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end
    // shadow_q mirrors what the downstream register holds after each edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data     <= 4'd0;
            dir      <= 1'b0;
            len      <= 3'd0;
            rem      <= 3'd0;
            shadow_q <= 4'd0;
        end else if (accept) begin
            data <= in_data;
            dir  <= in_dir;
            len  <= (in_len > 3'd4) ? 3'd4 : in_len;
        end else if (state == LOAD) begin
            shadow_q <= data;
            rem      <= len;
        end else if (state == SHIFT) begin
            shadow_q <= dir ? {shadow_q[2:0], 1'b0} : {1'b0, shadow_q[3:1]};
            rem      <= rem - 3'd1;
        end
    end
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        done     = (state == DONE);
        usr_cnt  = (state == LOAD) ? 2'b11 : (state == SHIFT) ? (dir ? 2'b10 : 2'b01) : 2'b00;
        usr_in   = (state == LOAD) ? data : 4'd0;
    end
`ifdef PES_USR_SEQ_SER_OUT_EN
    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid & (dir ? shadow_q[3] : shadow_q[0]);
`else
    assign ser_valid = 1'b0;
    assign ser_out   = 1'b0;
`endif
endmodule

// File: tb/tb_pes_usr_seq.sv
// tb_pes_usr_seq: directed self-checking bench for pes_usr_seq.
// Serial-tap expectations follow PES_USR_SEQ_SER_OUT_EN so the same bench covers both builds.
module tb_pes_usr_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_dir = 1'b0;
    logic [2:0] in_len = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] usr_cnt;
    logic [3:0] usr_in;
    logic       busy;
    logic       done;
    logic [3:0] shadow_q;
    logic       ser_out;
    logic       ser_valid;
    int         passed = 0;
    int         total = 0;
`ifdef PES_USR_SEQ_SER_OUT_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    pes_usr_seq dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_len(in_len),
        .in_valid(in_valid), .in_ready(in_ready), .usr_cnt(usr_cnt), .usr_in(usr_in),
        .busy(busy), .done(done), .shadow_q(shadow_q), .ser_out(ser_out), .ser_valid(ser_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Checks every output against one expected vector
    task automatic outs(input string tag, input logic rdy, input logic [1:0] cnt, input logic [3:0] uin,
                        input logic bsy, input logic dn, input logic [3:0] q, input logic so, input logic sv);
        chk({tag, ".in_ready"}, {3'd0, in_ready}, {3'd0, rdy});
        chk({tag, ".usr_cnt"}, {2'd0, usr_cnt}, {2'd0, cnt});
        chk({tag, ".usr_in"}, usr_in, uin);
        chk({tag, ".busy"}, {3'd0, busy}, {3'd0, bsy});
        chk({tag, ".done"}, {3'd0, done}, {3'd0, dn});
        chk({tag, ".shadow_q"}, shadow_q, q);
        chk({tag, ".ser_out"}, {3'd0, ser_out}, {3'd0, so & SER});
        chk({tag, ".ser_valid"}, {3'd0, ser_valid}, {3'd0, sv & SER});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] d, input logic dr, input logic [2:0] l);
        in_data = d;
        in_dir = dr;
        in_len = l;
        in_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #3 outs("reset", 1, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        #9 rst = 1'b1;
        step();
        outs("idle", 1, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        // right shift by 2; accept cycle is cycle 0, done in cycle 4
        req(4'b1011, 1'b0, 3'd2);
        step(); in_valid = 1'b0;
        outs("r2.load", 0, 2'b11, 4'b1011, 1, 0, 4'b0000, 0, 0);
        step(); outs("r2.sh1", 0, 2'b01, 4'd0, 1, 0, 4'b1011, 1, 1);
        step(); outs("r2.sh2", 0, 2'b01, 4'd0, 1, 0, 4'b0101, 1, 1);
        step(); outs("r2.done", 0, 2'b00, 4'd0, 1, 1, 4'b0010, 0, 0);
        step(); outs("r2.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0010, 0, 0);
        // left shift, len 7 clamps to 4
        req(4'b1011, 1'b1, 3'd7);
        step(); in_valid = 1'b0;
        outs("l7.load", 0, 2'b11, 4'b1011, 1, 0, 4'b0010, 0, 0);
        step(); outs("l7.sh1", 0, 2'b10, 4'd0, 1, 0, 4'b1011, 1, 1);
        step(); outs("l7.sh2", 0, 2'b10, 4'd0, 1, 0, 4'b0110, 0, 1);
        step(); outs("l7.sh3", 0, 2'b10, 4'd0, 1, 0, 4'b1100, 1, 1);
        step(); outs("l7.sh4", 0, 2'b10, 4'd0, 1, 0, 4'b1000, 1, 1);
        step(); outs("l7.done", 0, 2'b00, 4'd0, 1, 1, 4'b0000, 0, 0);
        step(); outs("l7.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0000, 0, 0);
        // len 0: LOAD then DONE
        req(4'b0110, 1'b0, 3'd0);
        step(); in_valid = 1'b0;
        outs("z.load", 0, 2'b11, 4'b0110, 1, 0, 4'b0000, 0, 0);
        step(); outs("z.done", 0, 2'b00, 4'd0, 1, 1, 4'b0110, 0, 0);
        step(); outs("z.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0110, 0, 0);
        // valid held across two requests: second accepted right after DONE
        req(4'b0001, 1'b0, 3'd1);
        step(); in_data = 4'b1001; in_dir = 1'b1;
        outs("bb.a.load", 0, 2'b11, 4'b0001, 1, 0, 4'b0110, 0, 0);
        step(); outs("bb.a.sh1", 0, 2'b01, 4'd0, 1, 0, 4'b0001, 1, 1);
        step(); outs("bb.a.done", 0, 2'b00, 4'd0, 1, 1, 4'b0000, 0, 0);
        step(); outs("bb.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0000, 0, 0);
        step(); in_valid = 1'b0;
        outs("bb.b.load", 0, 2'b11, 4'b1001, 1, 0, 4'b0000, 0, 0);
        step(); outs("bb.b.sh1", 0, 2'b10, 4'd0, 1, 0, 4'b1001, 1, 1);
        step(); outs("bb.b.done", 0, 2'b00, 4'd0, 1, 1, 4'b0010, 0, 0);
        step(); outs("bb.b.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0010, 0, 0);
        // asynchronous reset mid-SHIFT, then a fresh request
        req(4'b1111, 1'b0, 3'd3);
        step(); in_valid = 1'b0;
        step(); outs("rs.sh1", 0, 2'b01, 4'd0, 1, 0, 4'b1111, 1, 1);
        #2 rst = 1'b0;
        #1 outs("rs.async", 1, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        step(); outs("rs.held1", 1, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        step(); outs("rs.held2", 1, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        #2 rst = 1'b1;
        req(4'b0011, 1'b1, 3'd1);
        step(); in_valid = 1'b0;
        outs("rs.load", 0, 2'b11, 4'b0011, 1, 0, 4'd0, 0, 0);
        step(); outs("rs.sh1b", 0, 2'b10, 4'd0, 1, 0, 4'b0011, 0, 1);
        step(); outs("rs.done", 0, 2'b00, 4'd0, 1, 1, 4'b0110, 0, 0);
        step(); outs("rs.idle", 1, 2'b00, 4'd0, 0, 0, 4'b0110, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pes_usr_seq.md
PES_USR_SEQ -- requirements
Module: pes_usr_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port in_data, input, 4 bits, word to load into the downstream shift register.
REQ-004 SHALL have port in_dir, input, 1 bit, shift direction: 0 = right (usr_cnt 01), 1 = left (usr_cnt 10).
REQ-005 SHALL have port in_len, input, 3 bits, number of shifts; values 5-7 clamp to 4.
REQ-006 SHALL have port in_valid, input, 1 bit, request present.
REQ-007 SHALL have port in_ready, output, 1 bit, request accepted on a cycle with in_valid=1 and in_ready=1.
REQ-008 SHALL have port usr_cnt, output, 2 bits, mode code to downstream: 00 hold, 01 right, 10 left, 11 load.
REQ-009 SHALL have port usr_in, output, 4 bits, parallel load data to downstream.
REQ-010 SHALL have port busy, output, 1 bit, high in LOAD, SHIFT and DONE states.
REQ-011 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have port shadow_q, output, 4 bits, internal model of downstream q after each edge.
REQ-013 SHALL have port ser_out, output, 1 bit, bit shifted out in the current shift cycle.
REQ-014 SHALL have port ser_valid, output, 1 bit, qualifies ser_out.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 SHALL hold in_ready=1 only in IDLE; IDLE->LOAD on accept, capturing in_data, in_dir and clamped in_len.
REQ-017 SHALL, in LOAD, drive usr_cnt=11 and usr_in=captured data for exactly one cycle; shadow_q<=data at the cycle end.
REQ-018 SHALL go LOAD->SHIFT if len>0, else LOAD->DONE.
REQ-019 SHALL, in SHIFT, drive usr_cnt=01 (dir=0) or 10 (dir=1) for exactly len cycles, decrementing a remaining-count each cycle.
REQ-020 SHALL update shadow_q per shift: right = {0,q[3:1]}, left = {q[2:0],0}, zero-fill, no wrap.
REQ-021 SHALL go SHIFT->DONE when the last shift cycle completes; DONE lasts one cycle with done=1, usr_cnt=00, then ->IDLE.
REQ-022 SHALL drive usr_cnt=00 and usr_in=0 in IDLE and DONE; usr_in=0 in all states except LOAD.
REQ-023 SHALL give latency from accept edge to done high of len+2 cycles (len=0 -> 2 cycles).
REQ-024 SHALL ignore in_valid while busy (in_ready=0); a request held through busy is accepted in the next IDLE cycle.
REQ-025 SHALL accept a new request in the IDLE cycle immediately following DONE (back-to-back, no extra bubble).

Reset
REQ-026 SHALL, while rst=0, force state IDLE, in_ready=1, usr_cnt=00, usr_in=0, busy=0, done=0, shadow_q=0, ser_out=0, ser_valid=0, regardless of clk.
REQ-027 SHALL abandon any operation in progress on reset assertion, with no done pulse; the first accept is possible on the first posedge after rst returns to 1.

Configuration
REQ-028 SHALL use macro PES_USR_SEQ_SER_OUT_EN: when defined, ser_valid=1 in each SHIFT cycle and ser_out=shadow_q[0] (right) or shadow_q[3] (left), combinationally; when undefined, ser_out and ser_valid are tied 0 and carry no logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: in_data=1011, dir=0, len=2 -> usr_cnt 11,01,01,00; shadow_q 1011,0101,0010; done 4 cycles after accept.
REQ-030 SHALL cover: in_data=1011, dir=1, len=7 -> clamped to 4 shifts (usr_cnt 10 x4); shadow_q final 0000; with macro, ser_out sequence 1,0,1,1.
REQ-031 SHALL cover: len=0, in_data=0110 -> LOAD then DONE; shadow_q=0110; done 2 cycles after accept; ser_valid never 1.
REQ-032 SHALL cover: in_valid held high across two requests -> in_ready=0 while busy; second request accepted in the cycle after done, no bubble.
REQ-033 SHALL cover: rst=0 asserted mid-SHIFT, off clock edge -> outputs take reset values immediately, no done pulse; a fresh request after release completes normally.
REQ-034 SHALL cover: a build without PES_USR_SEQ_SER_OUT_EN running the REQ-030 stimulus -> ser_out=ser_valid=0 throughout, all other outputs identical.
